// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the load/store stage and data_memory_ctrl.
// The master issues requests; the slave (memory controller) answers with a one-cycle response.
interface data_memory_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        busy;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with byte/half/word access, valid/ready handshake,
// programmable wait states and fault reporting for misaligned or out-of-range accesses.
module data_memory_ctrl #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input logic               clk,
   input logic               rst_n,
   data_memory_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        we_r;
   logic [1:0]  size_r;
   logic        uns_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic        rsp_valid_r;
   logic [31:0] rsp_rdata_r;
   logic        rsp_fault_r;

   // Contents are not reset; they only start out cleared.
   logic [31:0] mem_r [DEPTH] = '{default: 32'd0};

   logic [AW-1:0] idx_s;
   logic [1:0]    lane_s;
   logic          fault_s;
   logic          access_s;
   logic [31:0]   word_s;

   function automatic logic access_fault(input logic [1:0] size, input logic [31:0] addr);
      logic f;
      case (size)
         2'b00:   f = 1'b0;
         2'b01:   f = addr[0];
         2'b10:   f = (addr[1:0] != 2'b00);
         default: f = 1'b1;
      endcase
      if ((addr >> (AW + 2)) != 32'd0) begin
         f = 1'b1;
      end else begin
         f = f;
      end
      return f;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {lane, 3'b000};
      case (size)
         2'b00:   r = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   r = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [1:0] lane, input logic [1:0] size);
      logic [3:0]  be;
      logic [31:0] data;
      logic [31:0] mask;
      case (size)
         2'b00: begin
            be   = 4'b0001 << lane;
            data = {4{wdata[7:0]}};
         end
         2'b01: begin
            be   = 4'b0011 << {lane[1], 1'b0};
            data = {2{wdata[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            data = wdata;
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return (old & ~mask) | (data & mask);
   endfunction

   assign idx_s    = addr_r[AW+1:2];
   assign lane_s   = addr_r[1:0];
   assign fault_s  = access_fault(size_r, addr_r);
   assign access_s = (state_r == ST_BUSY) && (cnt_r == 4'd0);
   assign word_s   = mem_r[idx_s];

   // Request FSM: latch the request, count wait states, then register the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         we_r        <= 1'b0;
         size_r      <= 2'b00;
         uns_r       <= 1'b0;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'd0;
         rsp_fault_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               rsp_valid_r <= 1'b0;
               rsp_rdata_r <= 32'd0;
               rsp_fault_r <= 1'b0;
               if (bus.req_valid) begin
                  we_r    <= bus.req_we;
                  size_r  <= bus.req_size;
                  uns_r   <= bus.req_unsigned;
                  addr_r  <= bus.req_addr;
                  wdata_r <= bus.req_wdata;
                  cnt_r   <= 4'(WAIT_CYCLES);
                  state_r <= ST_BUSY;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  rsp_valid_r <= 1'b1;
                  rsp_fault_r <= fault_s;
                  rsp_rdata_r <= (fault_s || we_r) ? 32'd0
                                                   : load_extract(word_s, lane_s, size_r, uns_r);
                  state_r     <= ST_RESP;
               end
            end
            ST_RESP: begin
               rsp_valid_r <= 1'b0;
               rsp_rdata_r <= 32'd0;
               rsp_fault_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
            default: begin
               rsp_valid_r <= 1'b0;
               rsp_rdata_r <= 32'd0;
               rsp_fault_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   // RAM write port: only legal stores reaching their access edge modify the array.
   always_ff @(posedge clk) begin
      if (access_s && we_r && !fault_s) begin
         mem_r[idx_s] <= store_merge(word_s, wdata_r, lane_s, size_r);
      end
   end

   assign bus.req_ready = (state_r == ST_IDLE);
   assign bus.busy      = (state_r != ST_IDLE);
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_fault = rsp_fault_r;
endmodule
